alu_mdu_cu: RTL and testbench

- Next-generation ALU control unit: keeps the single-cycle alu_op/func to ALUcontrol decode.
- Adds an iterative unsigned multiply/divide unit (MDU) with a start/busy/done handshake and HI/LO result registers.
- Sits between the multicycle controller FSM and the datapath.
- Controller holds its state while `stall` is high.
- Datapath operand width is parametrised.

---
 rtl/alu_mdu_cu_pkg.sv | 49 ++++
 rtl/alu_mdu_cu_if.sv | 28 ++
 rtl/alu_mdu_cu_mdu_iter.sv | 70 +++++++
 rtl/alu_mdu_cu.sv | 147 ++++++++++++++
 tb/tb_alu_mdu_cu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_cu_pkg.sv
// Shared definitions for the ALU control unit and its multiply/divide unit:
// ALU control codes, alu_op encodings, function codes and the MDU state enum.
// Optional macro ALU_MDU_SIGNED_EN adds the signed MULT/DIV functions.
package alu_cu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    localparam logic [5:0] FUNC_AND   = 6'b000001;
    localparam logic [5:0] FUNC_OR    = 6'b000010;
    localparam logic [5:0] FUNC_ADD   = 6'b000100;
    localparam logic [5:0] FUNC_SUB   = 6'b001000;
    localparam logic [5:0] FUNC_SLT   = 6'b010000;
    localparam logic [5:0] FUNC_MULTU = 6'b100000;
    localparam logic [5:0] FUNC_DIVU  = 6'b100010;
    localparam logic [5:0] FUNC_MULT  = 6'b100001;
    localparam logic [5:0] FUNC_DIV   = 6'b100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

    // True for every function code that launches the multiply/divide unit.
    function automatic logic is_mdu_func(input logic [5:0] f);
`ifdef ALU_MDU_SIGNED_EN
        return (f == FUNC_MULTU) || (f == FUNC_DIVU) || (f == FUNC_MULT) || (f == FUNC_DIV);
`else
        return (f == FUNC_MULTU) || (f == FUNC_DIVU);
`endif
    endfunction

    // Selects the divide iteration; only consulted when an MDU op starts.
    function automatic logic is_div_func(input logic [5:0] f);
        return (f == FUNC_DIVU) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_cu_if.sv
// Instruction/result bus between the multicycle controller and alu_mdu_cu.
interface alu_mdu_cu_if #(parameter int WIDTH = 32);
    import alu_cu_pkg::*;

    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUcontrol;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alu_op, func, valid, a, b,
        input  ALUcontrol, busy, stall, done, div0, hi, lo
    );

    modport slave (
        input  alu_op, func, valid, a, b,
        output ALUcontrol, busy, stall, done, div0, hi, lo
    );

endinterface

// File: rtl/alu_mdu_cu_mdu_iter.sv
// Iterative datapath of the MDU: operand, 2*WIDTH accumulator and iteration
// counter. Multiply is shift-add (multiplier LSB first, held in the low half);
// divide is restoring (remainder in the high half, quotient shifted into the
// low half MSB first). res_hi_o/res_lo_o show the accumulator after this step.
module mdu_iter
    import alu_cu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             opnd_zero_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   count_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [2*WIDTH-1:0] step_nxt;

    // One multiply or divide iteration computed from the current accumulator.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, opnd_q});
        // The true difference is always below 2^WIDTH, so a WIDTH-bit subtract suffices.
        rem_nxt  = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
        step_nxt = div_i ? {rem_nxt, acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
    end

    // Operand and accumulator: loaded at accept, updated once per iteration.
    always_ff @(posedge clk) begin
        if (load_i) begin
            acc_q  <= {{WIDTH{1'b0}}, (div_i ? opa_i : opb_i)};
            opnd_q <= div_i ? opb_i : opa_i;
        end else if (step_i) begin
            acc_q  <= step_nxt;
        end
    end

    // Iteration counter: WIDTH at accept, last iteration runs when it reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CNT_W'(WIDTH);
        end else if (step_i) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign count_o     = count_q;
    assign res_hi_o    = step_nxt[2*WIDTH-1:WIDTH];
    assign res_lo_o    = step_nxt[WIDTH-1:0];
    assign opnd_zero_o = (opnd_q == '0);

endmodule

// File: rtl/alu_mdu_cu.sv
// ALU control unit: combinational alu_op/func decode plus the FSM that drives
// the iterative multiply/divide unit and holds the HI/LO result registers.
// Optional macro ALU_MDU_SIGNED_EN enables signed MULT/DIV with sign fix-up.
module alu_mdu_cu
    import alu_cu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    alu_mdu_cu_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div0_q, div0_d;
    logic             mdu_req, start, load, step, div_mode, finish;
    logic [WIDTH-1:0] opa, opb, res_hi, res_lo;
    logic [CNT_W-1:0] count;
    logic             opnd_zero;

    function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] f);
        logic [2:0] ctl;
        ctl = ALU_NOP;
        case (op)
            ALUOP_MEM:  ctl = ALU_ADD;
            ALUOP_BEQ:  ctl = ALU_SUB;
            ALUOP_SLTI: ctl = ALU_SLT;
            default: begin
                case (f)
                    FUNC_AND: ctl = ALU_AND;
                    FUNC_OR:  ctl = ALU_OR;
                    FUNC_ADD: ctl = ALU_ADD;
                    FUNC_SUB: ctl = ALU_SUB;
                    FUNC_SLT: ctl = ALU_SLT;
                    default:  ctl = ALU_NOP;
                endcase
            end
        endcase
        return ctl;
    endfunction

    assign mdu_req        = bus.valid && (bus.alu_op == ALUOP_RTYPE) && is_mdu_func(bus.func);
    assign start          = mdu_req && (state_q == S_IDLE);
    assign bus.ALUcontrol = alu_decode(bus.alu_op, bus.func);
    assign bus.busy       = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.stall      = mdu_req && (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.div0       = div0_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign finish         = bus.busy && (count == CNT_W'(1));
    assign div_mode       = (state_q == S_IDLE) ? is_div_func(bus.func) : (state_q == S_DIV);

`ifdef ALU_MDU_SIGNED_EN
    logic sgn_op, neg_a, neg_b, neg_res_q, neg_rem_q;

    assign sgn_op = (bus.func == FUNC_MULT) || (bus.func == FUNC_DIV);
    assign neg_a  = sgn_op && bus.a[WIDTH-1];
    assign neg_b  = sgn_op && bus.b[WIDTH-1];
    assign opa    = neg_a ? -bus.a : bus.a;
    assign opb    = neg_b ? -bus.b : bus.b;

    // Result signs captured at accept; the iteration itself works on magnitudes.
    always_ff @(posedge clk) begin
        if (load) begin
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
        end
    end
`else
    assign opa = bus.a;
    assign opb = bus.b;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and iteration controls; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = is_div_func(bus.func) ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (count == CNT_W'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Final result with sign fix-up, captured on the edge that enters DONE.
    always_comb begin
        hi_d   = res_hi;
        lo_d   = res_lo;
        div0_d = 1'b0;
        if (state_q == S_DIV) begin
            div0_d = opnd_zero;
`ifdef ALU_MDU_SIGNED_EN
            if (neg_res_q && !opnd_zero) lo_d = -res_lo;
            if (neg_rem_q)               hi_d = -res_hi;
        end else if (neg_res_q) begin
            {hi_d, lo_d} = -{res_hi, res_lo};
`endif
        end
    end

    // HI/LO/div0 hold between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            div0_q <= 1'b0;
        end else if (finish) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            div0_q <= div0_d;
        end
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .step_i      (step),
        .div_i       (div_mode),
        .opa_i       (opa),
        .opb_i       (opb),
        .count_o     (count),
        .res_hi_o    (res_hi),
        .res_lo_o    (res_lo),
        .opnd_zero_o (opnd_zero)
    );

endmodule

// File: tb/tb_alu_mdu_cu.sv
// Directed bench for alu_mdu_cu at WIDTH=32: decode sweep, MULTU/DIVU results
// and latency, divide by zero, back-to-back stall, reset mid-operation.
module tb_alu_mdu_cu;
    import alu_cu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   lat, bcyc, npulse;

    always #5 clk = ~clk;

    alu_mdu_cu_if #(.WIDTH(W)) cu ();

    alu_mdu_cu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cu.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        cu.alu_op = ALUOP_RTYPE;
        cu.func   = f;
        cu.a      = av;
        cu.b      = bv;
        cu.valid  = 1'b1;
    endtask

    // Edges from the current sample point until done is seen (bounded).
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        while (cu.done !== 1'b1 && l < 100) begin
            if (cu.busy === 1'b1) bc++;
            step();
            l++;
        end
    endtask

    initial begin
        logic [5:0] fl [7];
        logic [2:0] rexp [7];
        logic [2:0] e;
        fl   = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b111111};
        rexp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b100, 3'b100};

        rst = 1'b1;
        cu.valid = 1'b0; cu.alu_op = 2'b00; cu.func = 6'b0; cu.a = '0; cu.b = '0;
        step(); step();
        chk("rst_busy", cu.busy, 0);
        chk("rst_done", cu.done, 0);
        chk("rst_div0", cu.div0, 0);
        chk("rst_hi", cu.hi, 0);
        chk("rst_lo", cu.lo, 0);
        chk("rst_stall", cu.stall, 0);
        rst = 1'b0;
        step();

        // Decode sweep
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 7; i++) begin
                cu.alu_op = 2'(op);
                cu.func   = fl[i];
                #1;
                e = (op == 2) ? rexp[i] : (op == 0) ? 3'b010 : (op == 1) ? 3'b011 : 3'b111;
                chk($sformatf("dec_op%0d_f%0h", op, fl[i]), cu.ALUcontrol, e);
            end
        end
        cu.alu_op = ALUOP_MEM; cu.func = FUNC_MULTU; cu.valid = 1'b1;
        step();
        chk("nonrtype_no_busy", cu.busy, 0);
        cu.valid = 1'b0;
        step();

        // MULTU max x max
        issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("mul_lat", lat, 32);
        chk("mul_busy_cycles", bcyc, 32);
        chk("mul_hi", cu.hi, 32'hFFFF_FFFE);
        chk("mul_lo", cu.lo, 32'h0000_0001);
        chk("mul_div0", cu.div0, 0);
        chk("mul_busy_at_done", cu.busy, 0);
        step();
        chk("done_pulse_one", cu.done, 0);
        chk("mul_hold_hi", cu.hi, 32'hFFFF_FFFE);

        // Back-to-back: second request while busy must stall and wait
        issue(FUNC_MULTU, 32'd6, 32'd7);
        step();
        issue(FUNC_MULTU, 32'd9, 32'd10);
        #1;
        chk("b2b_stall", cu.stall, 1);
        chk("b2b_busy", cu.busy, 1);
        wait_done(lat, bcyc);
        chk("b2b_lat1", lat, 32);
        chk("b2b_lo1", cu.lo, 42);
        chk("b2b_hi1", cu.hi, 0);
        step();
        chk("b2b_idle_stall", cu.stall, 0);
        chk("b2b_idle_busy", cu.busy, 0);
        step();
        chk("b2b_accept", cu.busy, 1);
        cu.alu_op = ALUOP_MEM;
        #1;
        chk("nonmdu_no_stall", cu.stall, 0);
        chk("alu_valid_busy", cu.ALUcontrol, 3'b010);
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("b2b_lat2", lat, 32);
        chk("b2b_lo2", cu.lo, 90);
        chk("b2b_hi2", cu.hi, 0);
        step();

        // DIVU
        issue(FUNC_DIVU, 32'd100, 32'd7);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("div_lat", lat, 32);
        chk("div_lo", cu.lo, 14);
        chk("div_hi", cu.hi, 2);
        chk("div_div0", cu.div0, 0);
        step();
        issue(FUNC_DIVU, 32'd5, 32'd0);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("div0_lat", lat, 32);
        chk("div0_lo", cu.lo, 32'hFFFF_FFFF);
        chk("div0_hi", cu.hi, 5);
        chk("div0_flag", cu.div0, 1);
        step();
        chk("div0_sticky", cu.div0, 1);
        chk("div0_hold_hi", cu.hi, 5);

        // Reset at iteration 10 of a DIVU
        issue(FUNC_DIVU, 32'd1000, 32'd3);
        step();
        cu.valid = 1'b0;
        repeat (9) step();
        chk("mid_busy", cu.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", cu.busy, 0);
        chk("mid_rst_hi", cu.hi, 0);
        chk("mid_rst_lo", cu.lo, 0);
        chk("mid_rst_div0", cu.div0, 0);
        npulse = 0;
        repeat (40) begin
            if (cu.done === 1'b1) npulse++;
            step();
        end
        chk("mid_rst_no_done", npulse, 0);

        // Reset wins over a simultaneous start
        issue(FUNC_MULTU, 32'd3, 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cu.valid = 1'b0;
        chk("rst_beats_start", cu.busy, 0);
        step();
        issue(FUNC_MULTU, 32'd3, 32'd4);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("post_rst_lo", cu.lo, 12);
        chk("post_rst_hi", cu.hi, 0);
        step();

`ifdef ALU_MDU_SIGNED_EN
        issue(FUNC_MULT, -32'sd3, 32'sd5);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("smul_lat", lat, 32);
        chk("smul_hi", cu.hi, 32'hFFFF_FFFF);
        chk("smul_lo", cu.lo, 32'hFFFF_FFF1);
        step();
        issue(FUNC_DIV, -32'sd7, 32'sd2);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("sdiv_lo", cu.lo, 32'hFFFF_FFFD);
        chk("sdiv_hi", cu.hi, 32'hFFFF_FFFF);
        step();
        issue(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        cu.valid = 1'b0;
        wait_done(lat, bcyc);
        chk("sdiv_min_lo", cu.lo, 32'h8000_0000);
        chk("sdiv_min_hi", cu.hi, 0);
        step();
`else
        cu.alu_op = ALUOP_RTYPE; cu.func = FUNC_MULT; cu.valid = 1'b1;
        #1;
        chk("mult_unknown_ctl", cu.ALUcontrol, 3'b100);
        step();
        chk("mult_unknown_no_start", cu.busy, 0);
        cu.func = FUNC_DIV;
        step();
        chk("div_unknown_no_start", cu.busy, 0);
        cu.valid = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
